eviction_buffer_control: RTL and testbench

EVICTION_BUFFER_CONTROL -- requirements
Module: eviction_buffer_control

---
 rtl/eviction_buffer_control_if.sv | 28 ++
 rtl/eviction_buffer_control.sv | 128 ++++++++++++
 tb/tb_eviction_buffer_control.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eviction_buffer_control_if.sv
// rtl/eviction_buffer_control_if.sv - lower-level, higher-level and datapath signals of the eviction buffer controller
interface eviction_buffer_control_if;
    logic       buf_mem_read;
    logic       buf_mem_write;
    logic       buf_mem_resp;
    logic [7:0] hits;
    logic       super_mem_read;
    logic       super_mem_write;
    logic       super_mem_resp;
    logic       load;
    logic [3:0] index;
    logic       valid;
    logic       dirty;
    logic       read_src_sel;
    logic [6:0] lru_in;

    modport master (
        output buf_mem_read, buf_mem_write, hits, super_mem_resp,
        input  buf_mem_resp, super_mem_read, super_mem_write, load, index,
               valid, dirty, read_src_sel, lru_in
    );

    modport slave (
        input  buf_mem_read, buf_mem_write, hits, super_mem_resp,
        output buf_mem_resp, super_mem_read, super_mem_write, load, index,
               valid, dirty, read_src_sel, lru_in
    );
endinterface

// File: rtl/eviction_buffer_control.sv
// rtl/eviction_buffer_control.sv - eviction buffer way allocation, tree-PLRU and writeback control FSM
module eviction_buffer_control (
    input  logic                      clk,
    input  logic                      reset,
    eviction_buffer_control_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD_HIT, RD_MISS, WB, INSTALL} state_t;

    state_t     state, state_nxt;
    logic [7:0] valid_vec, dirty_vec;
    logic [6:0] plru, plru_upd;
    logic [2:0] victim, victim_nxt;
    logic [7:0] qhit;
    logic [2:0] way_hit, free_way, tree_way, sel_way;
    logic       free_found;

    assign qhit = bus.hits & valid_vec;

    always_comb begin
        way_hit = '0;
        for (int i = 0; i < 8; i++)
            if (qhit[i]) way_hit = 3'(i);
    end

    // Descending scan so the lowest invalid way wins.
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int i = 7; i >= 0; i--)
            if (!valid_vec[i]) begin
                free_found = 1'b1;
                free_way   = 3'(i);
            end
    end

    assign tree_way = plru[0] ? {1'b1, plru[2], plru[2] ? plru[6] : plru[5]}
                              : {1'b0, plru[1], plru[1] ? plru[4] : plru[3]};
    assign sel_way  = free_found ? free_way : tree_way;

    always_comb begin
        plru_upd    = plru;
        plru_upd[0] = ~victim[2];
        if (!victim[2]) begin
            plru_upd[1] = ~victim[1];
            if (!victim[1]) plru_upd[3] = ~victim[0];
            else            plru_upd[4] = ~victim[0];
        end else begin
            plru_upd[2] = ~victim[1];
            if (!victim[1]) plru_upd[5] = ~victim[0];
            else            plru_upd[6] = ~victim[0];
        end
    end

    // Gated so every output reads zero while reset is held.
    assign bus.lru_in = reset ? 7'd0 : plru_upd;

    always_comb begin
        state_nxt            = state;
        victim_nxt           = victim;
        bus.load             = 1'b0;
        bus.index            = 4'd0;
        bus.valid            = 1'b0;
        bus.dirty            = 1'b0;
        bus.buf_mem_resp     = 1'b0;
        bus.super_mem_read   = 1'b0;
        bus.super_mem_write  = 1'b0;
        bus.read_src_sel     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.buf_mem_write) begin
                    if (|qhit) begin
                        victim_nxt = way_hit;
                        state_nxt  = INSTALL;
                    end else begin
                        victim_nxt = sel_way;
                        state_nxt  = (valid_vec[sel_way] && dirty_vec[sel_way]) ? WB : INSTALL;
                    end
                end else if (bus.buf_mem_read) begin
                    state_nxt = (|qhit) ? RD_HIT : RD_MISS;
                end
            end
            RD_HIT: begin
                bus.index        = {1'b0, way_hit};
                bus.buf_mem_resp = 1'b1;
                state_nxt        = IDLE;
            end
            RD_MISS: begin
                bus.index          = 4'd8;
                bus.read_src_sel   = 1'b1;
                bus.super_mem_read = 1'b1;
                bus.buf_mem_resp   = bus.super_mem_resp;
                if (bus.super_mem_resp) state_nxt = IDLE;
            end
            WB: begin
                bus.index           = {1'b0, victim};
                bus.super_mem_write = 1'b1;
                if (bus.super_mem_resp) state_nxt = INSTALL;
            end
            INSTALL: begin
                bus.load         = 1'b1;
                bus.index        = {1'b0, victim};
                bus.valid        = 1'b1;
                bus.dirty        = 1'b1;
                bus.buf_mem_resp = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            valid_vec <= '0;
            dirty_vec <= '0;
            plru      <= '0;
            victim    <= '0;
        end else begin
            state  <= state_nxt;
            victim <= victim_nxt;
            if (state == INSTALL) begin
                valid_vec[victim] <= 1'b1;
                dirty_vec[victim] <= 1'b1;
                plru              <= plru_upd;
            end
        end
    end
endmodule

// File: tb/tb_eviction_buffer_control.sv
// tb/tb_eviction_buffer_control.sv - scoreboard bench for eviction_buffer_control
module tb_eviction_buffer_control;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    eviction_buffer_control_if bus ();
    eviction_buffer_control dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic [3:0] index;
        logic       wb;
        logic       miss;
        logic [6:0] lru;
        int         lat;
    } exp_t;

    typedef struct {
        logic [3:0] index;
        logic       load, valid, dirty, rsel;
        logic [6:0] lru;
        logic       wb_seen, rd_seen, wb_moved;
        logic [3:0] wb_index;
        int         lat;
    } obs_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] cur_addr = '0;
    logic        hits_all = 1'b0;
    logic [31:0] dp_tag [8];
    logic [7:0]  dp_set = '0;
    logic [7:0]  dp_hits;
    logic [7:0]  m_valid = '0;
    logic [7:0]  m_dirty = '0;
    logic [6:0]  m_plru  = '0;
    logic [31:0] m_tag [8];

    // Datapath stand-in: tag store written whenever the controller loads an entry.
    always_comb begin
        dp_hits = '0;
        for (int w = 0; w < 8; w++) dp_hits[w] = dp_set[w] && (dp_tag[w] == cur_addr);
    end
    assign bus.hits = hits_all ? 8'hFF : dp_hits;

    always @(posedge clk)
        if (bus.load && !bus.index[3]) begin
            dp_tag[bus.index[2:0]] <= cur_addr;
            dp_set[bus.index[2:0]] <= 1'b1;
        end

    function automatic logic [2:0] m_victim();
        int n = 0;
        for (int w = 0; w < 8; w++) if (!m_valid[w]) return 3'(w);
        for (int l = 0; l < 3; l++) n = 2 * n + 1 + int'(m_plru[n]);
        return 3'(n - 7);
    endfunction

    function automatic logic [6:0] m_touch(input logic [6:0] p, input logic [2:0] w);
        int n = 0;
        for (int l = 2; l >= 0; l--) begin
            p[n] = ~w[l];
            n    = 2 * n + 1 + int'(w[l]);
        end
        return p;
    endfunction

    task automatic predict(input logic wr, input logic [31:0] addr, input int sm_lat);
        exp_t       e;
        logic       hit;
        logic [2:0] way;
        hit = 1'b0;
        way = '0;
        for (int w = 0; w < 8; w++)
            if (m_valid[w] && m_tag[w] == addr) begin hit = 1'b1; way = 3'(w); end
        e.wb = 1'b0; e.miss = 1'b0; e.lru = '0;
        if (wr) begin
            if (!hit) way = m_victim();
            e.wb    = !hit && m_valid[way] && m_dirty[way];
            e.index = {1'b0, way};
            e.lru   = m_touch(m_plru, way);
            e.lat   = e.wb ? sm_lat + 2 : 2;
            m_valid[way] = 1'b1; m_dirty[way] = 1'b1; m_plru = e.lru; m_tag[way] = addr;
        end else if (hit) begin
            e.index = {1'b0, way}; e.lat = 2;
        end else begin
            e.index = 4'd8; e.miss = 1'b1; e.lat = sm_lat + 1;
        end
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_valid = '0; m_dirty = '0; m_plru = '0;
    endtask

    // Request cycle counts as cycle 1; lat is the cycle in which buf_mem_resp is seen.
    task automatic drive(input logic wr, input logic [31:0] addr, input int sm_lat, output obs_t o);
        int cyc = 0;
        int smcnt = 0;
        bit done = 0;
        o = '{default: '0};
        @(negedge clk);
        cur_addr = addr;
        bus.buf_mem_write = wr;
        bus.buf_mem_read  = !wr;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.super_mem_resp = 1'b0;
            if (bus.super_mem_write) begin
                if (o.wb_seen && bus.index != o.wb_index) o.wb_moved = 1'b1;
                if (!o.wb_seen) o.wb_index = bus.index;
                o.wb_seen = 1'b1;
                smcnt++;
            end
            if (bus.super_mem_read) begin o.rd_seen = 1'b1; smcnt++; end
            if ((bus.super_mem_write || bus.super_mem_read) && smcnt == sm_lat) begin
                bus.super_mem_resp = 1'b1;
                #1;
            end
            if (bus.buf_mem_resp) begin
                o.index = bus.index; o.load = bus.load; o.valid = bus.valid;
                o.dirty = bus.dirty; o.rsel = bus.read_src_sel; o.lru = bus.lru_in;
                o.lat = cyc + 1;
                done = 1;
            end
        end
        if (done && bus.super_mem_read) begin @(posedge clk); #1; end
        bus.buf_mem_write  = 1'b0;
        bus.buf_mem_read   = 1'b0;
        bus.super_mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.buf_mem_write = 1'b1; bus.buf_mem_read = 1'b1; hits_all = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.buf_mem_resp, bus.super_mem_read, bus.super_mem_write, bus.load, bus.index,
             bus.valid, bus.dirty, bus.read_src_sel, bus.lru_in} !== 18'h0) begin
            fails++; $display("FAIL reset_outputs got idx=%0h lru=%0h resp=%0b exp all zero",
                              bus.index, bus.lru_in, bus.buf_mem_resp);
        end
        bus.buf_mem_write = 1'b0; bus.buf_mem_read = 1'b0; hits_all = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_raw_hits_masked();
        obs_t o; exp_t e;
        hits_all = 1'b1;
        predict(1'b0, 32'h1000, 3);
        drive(1'b0, 32'h1000, 3, o);
        hits_all = 1'b0;
        e = sb.pop_front();
        tests++; if (o.rd_seen !== 1'b1) begin fails++; $display("FAIL masked.rd_seen got %0b exp 1", o.rd_seen); end
        tests++; if (o.index !== e.index) begin fails++; $display("FAIL masked.index got %0d exp %0d", o.index, e.index); end
        tests++; if (o.lat !== e.lat) begin fails++; $display("FAIL masked.lat got %0d exp %0d", o.lat, e.lat); end
    endtask

    task automatic test_first_write();
        obs_t o; exp_t e;
        predict(1'b1, 32'h1000, 3);
        drive(1'b1, 32'h1000, 3, o);
        e = sb.pop_front();
        tests++; if (o.index !== 4'd0) begin fails++; $display("FAIL first_write.index got %0d exp 0", o.index); end
        tests++; if (o.lat !== 2) begin fails++; $display("FAIL first_write.lat got %0d exp 2", o.lat); end
        tests++; if (o.lru !== 7'h0B || e.lru !== 7'h0B) begin fails++; $display("FAIL first_write.lru got %0h exp 0b", o.lru); end
        tests++; if ({o.load, o.valid, o.dirty, o.wb_seen} !== 4'b1110) begin
            fails++; $display("FAIL first_write.ctl got %b exp 1110", {o.load, o.valid, o.dirty, o.wb_seen}); end
    endtask

    task automatic test_fill_and_evict();
        obs_t o; exp_t e;
        for (int i = 1; i < 8; i++) begin
            predict(1'b1, 32'h1000 + 32'(i * 16), 3);
            drive(1'b1, 32'h1000 + 32'(i * 16), 3, o);
            e = sb.pop_front();
            tests++;
            if (o.index !== e.index || o.wb_seen !== 1'b0 || o.lru !== e.lru || o.lat !== e.lat) begin
                fails++; $display("FAIL fill[%0d] got idx=%0d wb=%0b lru=%0h lat=%0d exp idx=%0d wb=0 lru=%0h lat=%0d",
                                  i, o.index, o.wb_seen, o.lru, o.lat, e.index, e.lru, e.lat);
            end
        end
        predict(1'b1, 32'h1080, 3);
        drive(1'b1, 32'h1080, 3, o);
        e = sb.pop_front();
        tests++; if (o.wb_seen !== 1'b1 || e.wb !== 1'b1) begin fails++; $display("FAIL evict.wb got %0b exp 1", o.wb_seen); end
        tests++; if (o.wb_index !== 4'd0 || o.wb_moved !== 1'b0) begin
            fails++; $display("FAIL evict.wb_index got %0d moved=%0b exp 0", o.wb_index, o.wb_moved); end
        tests++; if (o.index !== 4'd0 || o.load !== 1'b1) begin fails++; $display("FAIL evict.install got idx=%0d load=%0b exp idx=0 load=1", o.index, o.load); end
        tests++; if (o.lat !== e.lat || o.lru !== e.lru) begin
            fails++; $display("FAIL evict.lat_lru got %0d/%0h exp %0d/%0h", o.lat, o.lru, e.lat, e.lru); end
    endtask

    task automatic test_read_hit();
        obs_t o; exp_t e;
        predict(1'b0, 32'h1030, 3);
        drive(1'b0, 32'h1030, 3, o);
        e = sb.pop_front();
        tests++; if (o.index !== 4'd3 || e.index !== 4'd3) begin fails++; $display("FAIL read_hit.index got %0d exp 3", o.index); end
        tests++; if ({o.rsel, o.load, o.rd_seen} !== 3'b000) begin
            fails++; $display("FAIL read_hit.ctl got %b exp 000", {o.rsel, o.load, o.rd_seen}); end
        tests++; if (o.lat !== 2) begin fails++; $display("FAIL read_hit.lat got %0d exp 2", o.lat); end
    endtask

    task automatic test_read_miss();
        obs_t o; exp_t e;
        predict(1'b0, 32'h2000, 5);
        drive(1'b0, 32'h2000, 5, o);
        e = sb.pop_front();
        tests++; if (o.index !== 4'd8 || o.rsel !== 1'b1) begin
            fails++; $display("FAIL read_miss.path got idx=%0d sel=%0b exp idx=8 sel=1", o.index, o.rsel); end
        tests++; if (o.lat !== e.lat || o.rd_seen !== 1'b1) begin
            fails++; $display("FAIL read_miss.lat got %0d exp %0d", o.lat, e.lat); end
        predict(1'b0, 32'h1030, 3);
        drive(1'b0, 32'h1030, 3, o);
        e = sb.pop_front();
        tests++; if (o.index !== e.index || o.lat !== 2) begin
            fails++; $display("FAIL read_miss.no_alloc got idx=%0d lat=%0d exp idx=%0d lat=2", o.index, o.lat, e.index); end
    endtask

    task automatic test_back_to_back();
        obs_t o; exp_t e; int lat; logic [31:0] a;
        predict(1'b1, 32'h1050, 3);
        drive(1'b1, 32'h1050, 3, o);
        e = sb.pop_front();
        tests++; if (o.index !== 4'd5 || o.wb_seen !== 1'b0 || o.lat !== 2 || o.lru !== e.lru) begin
            fails++; $display("FAIL write_hit got idx=%0d wb=%0b lat=%0d lru=%0h exp idx=5 wb=0 lat=2 lru=%0h",
                              o.index, o.wb_seen, o.lat, o.lru, e.lru); end
        for (int i = 0; i < 6; i++) begin
            lat = int'($urandom_range(1, 4));
            a   = 32'h3000 + 32'(i * 16);
            predict(1'b1, a, lat);
            drive(1'b1, a, lat, o);
            e = sb.pop_front();
            tests++;
            if (o.index !== e.index || o.wb_seen !== e.wb || o.lat !== e.lat || o.lru !== e.lru ||
                (e.wb && o.wb_index !== e.index)) begin
                fails++; $display("FAIL b2b_wr[%0d] got idx=%0d wb=%0b lat=%0d lru=%0h exp idx=%0d wb=%0b lat=%0d lru=%0h",
                                  i, o.index, o.wb_seen, o.lat, o.lru, e.index, e.wb, e.lat, e.lru);
            end
            predict(1'b0, a, lat);
            drive(1'b0, a, lat, o);
            e = sb.pop_front();
            tests++;
            if (o.index !== e.index || o.lat !== e.lat || o.rsel !== 1'b0) begin
                fails++; $display("FAIL b2b_rd[%0d] got idx=%0d lat=%0d exp idx=%0d lat=%0d", i, o.index, o.lat, e.index, e.lat);
            end
        end
    endtask

    task automatic test_reset_mid_wb();
        obs_t o; exp_t e; int n = 0;
        @(negedge clk);
        cur_addr = 32'h4000;
        bus.buf_mem_write = 1'b1;
        while (!bus.super_mem_write && n < 20) begin @(negedge clk); n++; end
        tests++; if (bus.super_mem_write !== 1'b1) begin fails++; $display("FAIL mid_wb.start got %0b exp 1", bus.super_mem_write); end
        #2 reset = 1'b1;
        #1;
        tests++; if (bus.super_mem_write !== 1'b0) begin fails++; $display("FAIL mid_wb.async_drop got %0b exp 0", bus.super_mem_write); end
        bus.buf_mem_write = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if ({bus.buf_mem_resp, bus.load, bus.index} !== 6'h0) begin
            fails++; $display("FAIL mid_wb.no_resp got resp=%0b load=%0b exp 0", bus.buf_mem_resp, bus.load); end
        reset = 1'b0;
        model_reset();
        hits_all = 1'b1;
        predict(1'b0, 32'h1030, 2);
        drive(1'b0, 32'h1030, 2, o);
        hits_all = 1'b0;
        e = sb.pop_front();
        tests++; if (o.index !== 4'd8 || e.miss !== 1'b1 || o.lat !== e.lat) begin
            fails++; $display("FAIL mid_wb.valid_cleared got idx=%0d lat=%0d exp idx=8 lat=%0d", o.index, o.lat, e.lat); end
        predict(1'b1, 32'h5000, 2);
        drive(1'b1, 32'h5000, 2, o);
        e = sb.pop_front();
        tests++; if (o.index !== 4'd0 || o.wb_seen !== 1'b0 || o.lru !== 7'h0B || o.lat !== 2) begin
            fails++; $display("FAIL mid_wb.reinstall got idx=%0d wb=%0b lru=%0h lat=%0d exp idx=0 wb=0 lru=0b lat=2",
                              o.index, o.wb_seen, o.lru, o.lat); end
    endtask

    initial begin
        bus.buf_mem_read   = 1'b0;
        bus.buf_mem_write  = 1'b0;
        bus.super_mem_resp = 1'b0;
        test_reset();
        test_raw_hits_masked();
        test_first_write();
        test_fill_and_evict();
        test_read_hit();
        test_read_miss();
        test_back_to_back();
        test_reset_mid_wb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end
endmodule
